// File: rtl/dma_write_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dma_write_engine                                             |
// | Description : AXI4 write-master DMA. Takes NUM_LANES*LANE_WIDTH-bit beats  |
// |               from the accelerator and writes them out as DATA_WIDTH-bit   |
// |               INCR bursts. Completion/error is reported on the cfg port.   |
// |               Optional macro DMA_WR_4K_BOUNDARY_EN: when defined, bursts   |
// |               are clipped so that none crosses a 4 KiB address boundary.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dma_write_engine #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int NUM_LANES     = 16,
  parameter int LANE_WIDTH    = 32,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  // config / control
  input  logic                            cfg_valid_i,
  input  logic                            cfg_start_i,
  input  logic [ADDR_WIDTH-1:0]           cfg_dst_addr_i,
  input  logic [ADDR_WIDTH-1:0]           cfg_size_i,
  output logic                            cfg_ready_o,
  output logic                            cfg_done_o,
  output logic                            cfg_error_o,
  // accelerator data
  input  logic                            data_valid_i,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] data_i,
  output logic                            data_ready_o,
  // AXI write address
  output logic                            axi_awvalid_o,
  input  logic                            axi_awready_i,
  output logic [ADDR_WIDTH-1:0]           axi_awaddr_o,
  output logic [7:0]                      axi_awlen_o,
  output logic [2:0]                      axi_awsize_o,
  output logic [1:0]                      axi_awburst_o,
  // AXI write data
  output logic                            axi_wvalid_o,
  input  logic                            axi_wready_i,
  output logic [DATA_WIDTH-1:0]           axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0]         axi_wstrb_o,
  output logic                            axi_wlast_o,
  // AXI write response
  input  logic                            axi_bvalid_i,
  output logic                            axi_bready_o,
  input  logic [1:0]                      axi_bresp_i,
  // status
  output logic                            busy_o
);

  localparam int BUF_W   = NUM_LANES * LANE_WIDTH;
  localparam int WPB     = BUF_W / DATA_WIDTH;
  localparam int BPW     = DATA_WIDTH / 8;
  localparam int BPW_LOG = $clog2(BPW);
  localparam int PTR_W   = (WPB > 1) ? $clog2(WPB) : 1;

  localparam logic [ADDR_WIDTH-1:0] C_WPB       = ADDR_WIDTH'(WPB);
  localparam logic [ADDR_WIDTH-1:0] C_MAX_BURST = ADDR_WIDTH'(MAX_BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] C_ONE       = ADDR_WIDTH'(1);
  localparam logic [PTR_W-1:0]      C_LAST_PTR  = PTR_W'(WPB - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WRITE_ADDR = 3'd1,
    S_WRITE_DATA = 3'd2,
    S_WRITE_RESP = 3'd3,
    S_DONE       = 3'd4,
    S_ERROR      = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   words_rem_q, words_rem_d;     // words still to be written
  logic [ADDR_WIDTH-1:0]   words_fetch_q, words_fetch_d; // words still to be pulled in
  logic [7:0]              awlen_q, awlen_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic [BUF_W-1:0]        buf_q, buf_d;
  logic                    buf_valid_q, buf_valid_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    data_ready_q, data_ready_d;

  logic [ADDR_WIDTH-1:0]   w_cfg_words;
  logic                    w_cfg_bad;
  logic [ADDR_WIDTH-1:0]   w_next_addr;
  logic [ADDR_WIDTH-1:0]   w_nb_words;
  logic [ADDR_WIDTH-1:0]   w_burst;
  logic                    w_wvalid;
  logic                    w_w_hs;
  logic                    w_fill;
  logic                    w_in_xfer_d;
  logic                    w_unused;
`ifdef DMA_WR_4K_BOUNDARY_EN
  logic [11:0]             w_nb_addr_lo;
  logic [ADDR_WIDTH-1:0]   w_4k_room;
`endif

  // Only bresp[1] distinguishes failure; bresp[0] (EXOKAY vs OKAY, SLVERR vs DECERR) is irrelevant here
  assign w_unused    = axi_bresp_i[0];

  assign w_cfg_words = cfg_size_i >> BPW_LOG;
  assign w_cfg_bad   = (cfg_size_i == '0) || (cfg_size_i[BPW_LOG-1:0] != '0);
  assign w_next_addr = addr_q + ((ADDR_WIDTH'(awlen_q) + C_ONE) << BPW_LOG);
  assign w_wvalid    = (state_q == S_WRITE_DATA) && buf_valid_q;
  assign w_w_hs      = w_wvalid && axi_wready_i;
  assign w_fill      = data_ready_q && data_valid_i;

  // Length (in words) of the burst about to be issued, from where it will start
  always_comb begin
    w_nb_words = (state_q == S_IDLE) ? w_cfg_words : words_rem_q;
    w_burst    = (w_nb_words < C_MAX_BURST) ? w_nb_words : C_MAX_BURST;
`ifdef DMA_WR_4K_BOUNDARY_EN
    w_nb_addr_lo = (state_q == S_IDLE) ? cfg_dst_addr_i[11:0] : w_next_addr[11:0];
    w_4k_room    = (ADDR_WIDTH'(4096) - ADDR_WIDTH'(w_nb_addr_lo)) >> BPW_LOG;
    if (w_4k_room < w_burst) begin
      w_burst = w_4k_room;
    end
`endif
  end

  // Next-state logic for the control FSM, counters and the wide buffer
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    words_rem_d   = words_rem_q;
    words_fetch_d = words_fetch_q;
    awlen_d       = awlen_q;
    beat_cnt_d    = beat_cnt_q;
    buf_d         = buf_q;
    buf_valid_d   = buf_valid_q;
    ptr_d         = ptr_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_valid_i && cfg_start_i) begin
          addr_d        = cfg_dst_addr_i;
          words_rem_d   = w_cfg_words;
          words_fetch_d = w_cfg_words;
          if (w_cfg_bad) begin
            state_d = S_ERROR;
          end else begin
            awlen_d = 8'(w_burst - C_ONE);
            state_d = S_WRITE_ADDR;
          end
        end
      end
      S_WRITE_ADDR: begin
        if (axi_awready_i) begin
          beat_cnt_d = awlen_q;
          state_d    = S_WRITE_DATA;
        end
      end
      S_WRITE_DATA: begin
        if (w_w_hs) begin
          words_rem_d = words_rem_q - C_ONE;
          if (beat_cnt_q == 8'd0) begin
            state_d = S_WRITE_RESP;
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
          end
        end
      end
      S_WRITE_RESP: begin
        if (axi_bvalid_i) begin
          if (axi_bresp_i[1]) begin
            state_d = S_ERROR;
          end else if (words_rem_q == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d  = w_next_addr;
            awlen_d = 8'(w_burst - C_ONE);
            state_d = S_WRITE_ADDR;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (!cfg_valid_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A fill and a last-slice drain never coincide: data_ready is only raised
    // the cycle after the buffer has emptied.
    if (w_fill) begin
      buf_d         = data_i;
      buf_valid_d   = 1'b1;
      ptr_d         = '0;
      words_fetch_d = (words_fetch_q > C_WPB) ? (words_fetch_q - C_WPB) : '0;
    end else if (w_w_hs) begin
      if (ptr_q == C_LAST_PTR) begin
        buf_valid_d = 1'b0;
        ptr_d       = '0;
      end else begin
        ptr_d = ptr_q + PTR_W'(1);
      end
    end

    // Unused tail slices of the final beat are dropped on completion
    if ((state_d == S_DONE || state_d == S_ERROR) && state_d != state_q) begin
      buf_valid_d = 1'b0;
      ptr_d       = '0;
    end
  end

  assign w_in_xfer_d = (state_d == S_WRITE_ADDR) || (state_d == S_WRITE_DATA) ||
                       (state_d == S_WRITE_RESP);
  assign data_ready_d = w_in_xfer_d && !buf_valid_d && (words_fetch_d != '0);

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      words_rem_q   <= '0;
      words_fetch_q <= '0;
      awlen_q       <= '0;
      beat_cnt_q    <= '0;
      buf_q         <= '0;
      buf_valid_q   <= 1'b0;
      ptr_q         <= '0;
      data_ready_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      words_rem_q   <= words_rem_d;
      words_fetch_q <= words_fetch_d;
      awlen_q       <= awlen_d;
      beat_cnt_q    <= beat_cnt_d;
      buf_q         <= buf_d;
      buf_valid_q   <= buf_valid_d;
      ptr_q         <= ptr_d;
      data_ready_q  <= data_ready_d;
    end
  end

  assign cfg_ready_o   = (state_q == S_IDLE);
  assign cfg_done_o    = (state_q == S_DONE);
  assign cfg_error_o   = (state_q == S_ERROR);
  assign busy_o        = (state_q != S_IDLE);
  assign data_ready_o  = data_ready_q;

  assign axi_awvalid_o = (state_q == S_WRITE_ADDR);
  assign axi_awaddr_o  = addr_q;
  assign axi_awlen_o   = awlen_q;
  assign axi_awsize_o  = 3'(BPW_LOG);
  assign axi_awburst_o = 2'b01;

  assign axi_wvalid_o  = w_wvalid;
  assign axi_wdata_o   = buf_q[int'(ptr_q)*DATA_WIDTH +: DATA_WIDTH];
  assign axi_wstrb_o   = w_wvalid ? '1 : '0;
  assign axi_wlast_o   = w_wvalid && (beat_cnt_q == 8'd0);

  assign axi_bready_o  = (state_q == S_WRITE_RESP);

endmodule
`default_nettype wire

// File: doc/dma_write_engine.md
# dma_write_engine

AXI4 write-master DMA that drains wide result vectors from the multi-lane unit and writes them to system memory. It is the memory-bound companion of the Garuda read DMA. It accepts `NUM_LANES*LANE_WIDTH`-bit beats from the accelerator, serializes them into `DATA_WIDTH`-bit INCR write bursts, and reports completion or error on a config/control handshake.

## Interface
Parameters:
- `DATA_WIDTH`, 32: AXI data width; legal values 32, 64, 128.
- `ADDR_WIDTH`, 32: address and size width.
- `NUM_LANES`, 16: lanes per accelerator beat.
- `LANE_WIDTH`, 32: bits per lane.
- `MAX_BURST_LEN`, 16: maximum beats per AXI burst (1..256).

Ports. One clock `clk_i`; reset `rst_ni` is synchronous and active-low.
- `clk_i` in 1: clock.
- `rst_ni` in 1: synchronous active-low reset.
- `cfg_valid_i` in 1: config request valid; also the done/error acknowledge.
- `cfg_start_i` in 1: start transfer.
- `cfg_dst_addr_i` in ADDR_WIDTH: memory destination byte address, `DATA_WIDTH/8`-aligned.
- `cfg_size_i` in ADDR_WIDTH: transfer size in bytes.
- `cfg_ready_o` out 1: engine idle, config accepted.
- `cfg_done_o` out 1: transfer completed OK.
- `cfg_error_o` out 1: transfer failed.
- `data_valid_i` in 1: accelerator beat valid.
- `data_i` in NUM_LANES*LANE_WIDTH: accelerator beat; lowest bits are written first.
- `data_ready_o` out 1: engine accepts `data_i`.
- `axi_awvalid_o` out 1, `axi_awready_i` in 1, `axi_awaddr_o` out ADDR_WIDTH, `axi_awlen_o` out 8, `axi_awsize_o` out 3, `axi_awburst_o` out 2: write address channel.
- `axi_wvalid_o` out 1, `axi_wready_i` in 1, `axi_wdata_o` out DATA_WIDTH, `axi_wstrb_o` out DATA_WIDTH/8, `axi_wlast_o` out 1: write data channel.
- `axi_bvalid_i` in 1, `axi_bready_o` out 1, `axi_bresp_i` in 2: write response channel.
- `busy_o` out 1: state is not IDLE.

## Operation
- Derived constants: `WPB = NUM_LANES*LANE_WIDTH/DATA_WIDTH` words per accelerator beat; `BPW = DATA_WIDTH/8` bytes per word.
- States and transitions:
  - IDLE: `cfg_ready_o=1`. On `cfg_valid_i && cfg_start_i`, latch address and size, then go to ERROR if size is 0 or `size % BPW != 0`, else go to WRITE_ADDR.
  - WRITE_ADDR: `awvalid=1`. `awlen = min(MAX_BURST_LEN, words_remaining) - 1`. `awsize = log2(BPW)`, `awburst = 2'b01`. On `awready`, go to WRITE_DATA with beat counter = awlen.
  - WRITE_DATA: `wvalid` = word buffer holds data. `wdata` = the current `DATA_WIDTH` slice. `wstrb` = all ones. `wlast` = beat counter is 0. Each `wvalid && wready` advances the slice pointer and decrements words_remaining. On the last handshake, go to WRITE_RESP.
  - WRITE_RESP: `bready=1`. On `bvalid`:
    - `bresp[1]=1` (SLVERR/DECERR): go to ERROR.
    - Otherwise, if words_remaining == 0, go to DONE.
    - Otherwise advance the address by `(awlen+1)*BPW` and go to WRITE_ADDR.
  - DONE / ERROR: hold `cfg_done_o` / `cfg_error_o` until `cfg_valid_i=0`, then go to IDLE.
- Wide buffer: a single `NUM_LANES*LANE_WIDTH` register plus a valid flag and a slice pointer of `$clog2(WPB)` bits.
  - `data_ready_o = !buf_valid && words_to_fetch > 0` in states WRITE_ADDR, WRITE_DATA and WRITE_RESP.
  - The buffer refills while the previous burst's AW or B is in flight.
  - The buffer becomes empty when the pointer wraps past `WPB-1`.
- A wide beat may span bursts. Unused tail slices of the final beat are discarded; `buf_valid` is cleared on entry to DONE or ERROR.
- All remaining-count arithmetic is in words, ADDR_WIDTH bits wide. Address increment wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset values: state IDLE, all counters and buffer 0. `cfg_ready_o=1`. All other outputs 0, except `axi_awsize_o` (constant) and `axi_awburst_o=2'b01`.
- AW and W fields are driven from registers. They remain stable while valid is high and not accepted; valid never drops without a handshake.
- Zero-wait path: config accepted at cycle 0, `awvalid` at cycle 1. The first `wvalid` comes one cycle after both the AW handshake and a buffer fill.
- Simultaneous buffer drain and refill: the last-slice handshake and a `data_valid_i` accept may not occur in the same cycle. `data_ready_o` is registered off `buf_valid`, adding one bubble per wide beat.
- `cfg_start_i` is ignored outside IDLE.
- Reset asserted mid-transfer: return to IDLE next edge with all valids deasserted. Outstanding AXI transactions are abandoned.

## Configuration
- `DMA_WR_4K_BOUNDARY_EN`:
  - Defined: burst length is additionally clipped so no burst crosses a 4 KiB address boundary, i.e. `awlen+1 <= (4096 - awaddr[11:0]) / BPW`.
  - Undefined: only `MAX_BURST_LEN` and words_remaining limit `awlen`.

## Test plan
- Single burst: DATA_WIDTH=32, addr 0x1000, size 64, one beat of 16 lanes, `wready` always 1 → one AW with `awlen=15`; 16 W beats carrying lanes 0..15 in order; `wlast` on the 16th beat; OKAY response → `cfg_done_o=1`.
- Multi-burst with tail discard: addr 0x2000, size 72, two beats → AW `awlen=15` at 0x2000, then AW `awlen=1` at 0x2040. Only lanes 0,1 of the second beat are written; then done.
- Backpressure: `wready` toggling 1,0,1,0 and `awready` delayed 3 cycles → `wdata`/`awaddr` held stable, no dropped or duplicated beats, identical memory image.
- Error response: `bresp=2'b10` on the first burst of a 128-byte transfer → ERROR, no second AW, `cfg_error_o` held until `cfg_valid_i=0`.
- Bad config: size 0 or size 6 → ERROR with no AW issued. Reset asserted mid WRITE_DATA → next cycle `wvalid=0`, `cfg_ready_o=1`.
- With `DMA_WR_4K_BOUNDARY_EN`: addr 0x0FF0, size 64 → AW `awlen=3` at 0x0FF0, then AW `awlen=11` at 0x1000.
